// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and
// drives ALU control, datapath muxes and the memory handshake. Option: MC_BRANCH_EXT_EN.
module mc_ctrl_fsm #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [2:0]  compare,
    input  logic        mem_ready,
    output logic [2:0]  alu_ctrl,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        ext_op,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic        i_or_d,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        instr_done,
    output logic        bus_err
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef MC_BRANCH_EXT_EN
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
`endif

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [3:0] {
        ST_RST, ST_FETCH, ST_DECODE, ST_EXE_R, ST_WB_R, ST_EXE_I, ST_WB_I, ST_MEM_ADDR,
        ST_MEM_RD, ST_WB_MEM, ST_MEM_WR, ST_BRANCH, ST_JUMP, ST_JR, ST_HALT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             bus_err_q, bus_err_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_r_alu;
    logic       is_jr;
    logic       is_branch;
    logic       br_taken;
    logic [2:0] r_alu_op;
    logic       unused_bits;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    // Register/immediate fields belong to the datapath, not to control decode.
    assign unused_bits = ^{instr[25:6], compare};
    assign bus_err = bus_err_q;

    // Instruction class decode and branch resolution.
    always_comb begin : decode
        is_r_alu  = 1'b0;
        is_jr     = 1'b0;
        is_branch = 1'b0;
        br_taken  = 1'b0;
        r_alu_op  = ALU_ADD;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADDU: begin is_r_alu = 1'b1; r_alu_op = ALU_ADD; end
                FN_SUBU: begin is_r_alu = 1'b1; r_alu_op = ALU_SUB; end
                FN_AND:  begin is_r_alu = 1'b1; r_alu_op = ALU_AND; end
                FN_OR:   begin is_r_alu = 1'b1; r_alu_op = ALU_OR;  end
                FN_SLT:  begin is_r_alu = 1'b1; r_alu_op = ALU_SLT; end
                FN_JR:   is_jr = 1'b1;
                default: ;
            endcase
        end
        case (opcode)
            OP_BEQ: begin is_branch = 1'b1; br_taken = compare[1]; end
`ifdef MC_BRANCH_EXT_EN
            OP_BNE:  begin is_branch = 1'b1; br_taken = !compare[1]; end
            OP_BLEZ: begin is_branch = (instr[20:16] == 5'd0); br_taken = compare[1] | compare[2]; end
            OP_BGTZ: begin is_branch = (instr[20:16] == 5'd0); br_taken = compare[0]; end
`endif
            default: ;
        endcase
    end

    // Next state, sticky error, wait counter and state-decoded control outputs.
    always_comb begin : next_state_and_outputs
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        bus_err_d  = bus_err_q;
        alu_ctrl   = ALU_AND;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_op     = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        instr_done = 1'b0;

        case (state_q)
            ST_RST: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_ctrl  = ALU_ADD;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_DECODE: begin
                alu_ctrl  = ALU_ADD;
                alu_src_b = 2'b11;
                if (is_r_alu)                                 state_d = ST_EXE_R;
                else if (opcode == OP_ORI || opcode == OP_LUI) state_d = ST_EXE_I;
                else if (opcode == OP_LW || opcode == OP_SW)   state_d = ST_MEM_ADDR;
                else if (is_branch)                           state_d = ST_BRANCH;
                else if (opcode == OP_J || opcode == OP_JAL)   state_d = ST_JUMP;
                else if (is_jr)                               state_d = ST_JR;
                else begin
                    instr_done = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            ST_EXE_R: begin
                alu_src_a = 1'b1;
                alu_ctrl  = r_alu_op;
                state_d   = ST_WB_R;
            end
            ST_WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b01;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_EXE_I: begin
                if (opcode == OP_ORI) begin
                    alu_ctrl  = ALU_OR;
                    alu_src_b = 2'b10;
                end
                state_d = ST_WB_I;
            end
            ST_WB_I: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode == OP_LUI) ? 2'b11 : 2'b00;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                alu_ctrl  = ALU_ADD;
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
                state_d   = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) begin
                    state_d = ST_WB_MEM;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = ST_FETCH;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_BRANCH: begin
                alu_ctrl   = ALU_SUB;
                alu_src_a  = 1'b1;
                pc_write   = br_taken;
                pc_src     = 2'b01;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
                if (opcode == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end
                state_d = ST_FETCH;
            end
            ST_JR: begin
                pc_write   = 1'b1;
                pc_src     = 2'b11;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_HALT: ;
            default: state_d = ST_RST;
        endcase

        // Count unacknowledged request cycles, restarting on entry to a memory-wait state.
        if ((state_d != state_q) &&
            (state_d == ST_FETCH || state_d == ST_MEM_RD || state_d == ST_MEM_WR)) begin
            wait_cnt_d = '0;
        end else if (mem_req && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin : state_regs
        if (!reset) begin
            state_q    <= ST_RST;
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed and random instructions checked cycle by cycle
// against an instruction-level model of each instruction's control sequence.
`timescale 1ns/1ps
module tb_mc_ctrl_fsm;
    localparam int unsigned MEM_WAIT_MAX = 15;
    localparam logic [2:0] A_AND = 3'b000;
    localparam logic [2:0] A_OR  = 3'b001;
    localparam logic [2:0] A_ADD = 3'b010;
    localparam logic [2:0] A_SUB = 3'b011;
    localparam logic [2:0] A_SLT = 3'b100;

    typedef struct packed {
        logic [2:0] alu_ctrl;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       instr_done;
        logic       bus_err;
    } ctl_t;

    typedef enum {K_NOP, K_RALU, K_ORI, K_LUI, K_LW, K_SW, K_BR, K_J, K_JAL, K_JR} kind_e;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic [2:0]  compare;
    logic        mem_ready;
    logic [2:0]  alu_ctrl;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        ext_op;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        ir_write;
    logic        mem_req;
    logic        mem_we;
    logic        i_or_d;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  mem_to_reg;
    logic        instr_done;
    logic        bus_err;

    ctl_t        obs;
    ctl_t        exp_q[$];
    logic        rdy_q[$];
    int unsigned n_vec;
    int unsigned n_err;

    mc_ctrl_fsm #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
        .clk(clk), .reset(reset), .instr(instr), .compare(compare), .mem_ready(mem_ready),
        .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_req(mem_req),
        .mem_we(mem_we), .i_or_d(i_or_d), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .instr_done(instr_done), .bus_err(bus_err)
    );

    assign obs = {alu_ctrl, alu_src_a, alu_src_b, ext_op, pc_write, pc_src, ir_write, mem_req,
                  mem_we, i_or_d, reg_write, reg_dst, mem_to_reg, instr_done, bus_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    function automatic kind_e classify(input logic [31:0] i);
        kind_e k;
        k = K_NOP;
        case (i[31:26])
            6'h00: begin
                if (i[5:0] == 6'h08) k = K_JR;
                else if (i[5:0] inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h2A}) k = K_RALU;
            end
            6'h02: k = K_J;
            6'h03: k = K_JAL;
            6'h04: k = K_BR;
            6'h0D: k = K_ORI;
            6'h0F: k = K_LUI;
            6'h23: k = K_LW;
            6'h2B: k = K_SW;
`ifdef MC_BRANCH_EXT_EN
            6'h05: k = K_BR;
            6'h06, 6'h07: if (i[20:16] == 5'd0) k = K_BR;
`endif
            default: ;
        endcase
        return k;
    endfunction

    // Branch outcome from the flags {A<B, A==B, A>B}.
    function automatic logic taken(input logic [31:0] i, input logic [2:0] c);
        case (i[31:26])
            6'h05:   return !c[1];
            6'h06:   return c[1] | c[2];
            6'h07:   return c[0];
            default: return c[1];
        endcase
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h21:   return A_ADD;
            6'h23:   return A_SUB;
            6'h24:   return A_AND;
            6'h25:   return A_OR;
            default: return A_SLT;
        endcase
    endfunction

    function automatic void push(input ctl_t c, input logic r);
        exp_q.push_back(c);
        rdy_q.push_back(r);
    endfunction

    function automatic void push_any(input ctl_t c);
        push(c, 1'($urandom_range(0, 1)));
    endfunction

    function automatic void push_halt(input int unsigned n);
        ctl_t c;
        c = '0;
        c.bus_err = 1'b1;
        for (int unsigned k = 0; k < n; k++) push_any(c);
    endfunction

    // Memory handshake: 'waits' unready cycles then the acknowledged one; 1 = timed out.
    function automatic bit mem_phase(input ctl_t w, input ctl_t d, input int unsigned waits);
        int unsigned n;
        n = (waits >= MEM_WAIT_MAX) ? MEM_WAIT_MAX : waits;
        for (int unsigned k = 0; k < n; k++) push(w, 1'b0);
        if (waits >= MEM_WAIT_MAX) return 1'b1;
        push(d, 1'b1);
        return 1'b0;
    endfunction

    // Expected per-cycle control vectors for one instruction; 1 = ends in a bus error.
    function automatic bit build(input logic [31:0] i, input logic [2:0] cmp,
                                 input int unsigned fw, input int unsigned mw);
        kind_e k;
        ctl_t  w, d;
        k = classify(i);
        w = '0; w.mem_req = 1'b1; w.alu_ctrl = A_ADD; w.alu_src_b = 2'b01;
        d = w;  d.ir_write = 1'b1; d.pc_write = 1'b1;
        if (mem_phase(w, d, fw)) return 1'b1;
        d = '0; d.alu_ctrl = A_ADD; d.alu_src_b = 2'b11; d.instr_done = (k == K_NOP);
        push_any(d);
        d = '0;
        case (k)
            K_RALU: begin
                d.alu_src_a = 1'b1; d.alu_ctrl = r_alu(i[5:0]); push_any(d);
                d = '0; d.reg_write = 1'b1; d.reg_dst = 2'b01; d.instr_done = 1'b1; push_any(d);
            end
            K_ORI: begin
                d.alu_ctrl = A_OR; d.alu_src_b = 2'b10; push_any(d);
                d = '0; d.reg_write = 1'b1; d.instr_done = 1'b1; push_any(d);
            end
            K_LUI: begin
                push_any(d);
                d.reg_write = 1'b1; d.mem_to_reg = 2'b11; d.instr_done = 1'b1; push_any(d);
            end
            K_LW, K_SW: begin
                d.alu_ctrl = A_ADD; d.alu_src_a = 1'b1; d.alu_src_b = 2'b10; d.ext_op = 1'b1;
                push_any(d);
                w = '0; w.mem_req = 1'b1; w.i_or_d = 1'b1; w.mem_we = (k == K_SW);
                d = w;  d.instr_done = (k == K_SW);
                if (mem_phase(w, d, mw)) return 1'b1;
                if (k == K_LW) begin
                    d = '0; d.reg_write = 1'b1; d.mem_to_reg = 2'b01; d.instr_done = 1'b1;
                    push_any(d);
                end
            end
            K_BR: begin
                d.alu_ctrl = A_SUB; d.alu_src_a = 1'b1; d.pc_write = taken(i, cmp);
                d.pc_src = 2'b01; d.instr_done = 1'b1; push_any(d);
            end
            K_J, K_JAL: begin
                d.pc_write = 1'b1; d.pc_src = 2'b10; d.instr_done = 1'b1;
                if (k == K_JAL) begin
                    d.reg_write = 1'b1; d.reg_dst = 2'b10; d.mem_to_reg = 2'b10;
                end
                push_any(d);
            end
            K_JR: begin
                d.pc_write = 1'b1; d.pc_src = 2'b11; d.instr_done = 1'b1; push_any(d);
            end
            default: ;
        endcase
        return 1'b0;
    endfunction

    task automatic check(input ctl_t e, input string tag);
        n_vec++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, e);
        end
    endtask

    task automatic run(input logic [31:0] i, input logic [2:0] cmp, input int unsigned n,
                       input string tag);
        ctl_t e;
        for (int unsigned k = 0; k < n && exp_q.size() != 0; k++) begin
            @(negedge clk);
            instr     = i;
            compare   = cmp;
            mem_ready = rdy_q.pop_front();
            e         = exp_q.pop_front();
            #1;
            check(e, tag);
        end
    endtask

    task automatic exec(input logic [31:0] i, input logic [2:0] cmp, input int unsigned fw,
                        input int unsigned mw, input string tag);
        if (build(i, cmp, fw, mw)) push_halt(5);
        run(i, cmp, 1000, tag);
    endtask

    // Asserts reset now, holds it two cycles, then releases into the RST cycle.
    task automatic apply_reset(input string tag);
        ctl_t zc;
        zc = '0;
        reset = 1'b0;
        #1;
        check(zc, tag);
        repeat (2) begin
            @(negedge clk);
            instr     = $urandom;
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            check(zc, tag);
        end
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        check(zc, tag);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [5:0]  fn;
        logic [31:0] r;
        rs  = 5'($urandom_range(0, 31));
        rt  = 5'($urandom_range(0, 31));
        rd  = 5'($urandom_range(0, 31));
        imm = 16'($urandom);
        case ($urandom_range(0, 4))
            0: fn = 6'h21;
            1: fn = 6'h23;
            2: fn = 6'h24;
            3: fn = 6'h25;
            default: fn = 6'h2A;
        endcase
        case ($urandom_range(0, 11))
            0, 1: r = {6'h00, rs, rt, rd, 5'd0, fn};
            2:    r = {6'h0D, rs, rt, imm};
            3:    r = {6'h0F, 5'd0, rt, imm};
            4:    r = {6'h23, rs, rt, imm};
            5:    r = {6'h2B, rs, rt, imm};
            6:    r = {6'h04, rs, rt, imm};
            7:    r = {6'(5 + $urandom_range(0, 2)), rs,
                       ($urandom_range(0, 1) != 0) ? 5'd0 : rt, imm};
            8:    r = {6'h02, 26'($urandom)};
            9:    r = {6'h03, 26'($urandom)};
            10:   r = {6'h00, rs, 15'd0, 6'h08};
            default: r = $urandom;
        endcase
        return r;
    endfunction

    initial begin
        int unsigned fw, mw;
        logic [31:0] ri;
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        instr     = '0;
        compare   = '0;
        mem_ready = 1'b0;
        @(negedge clk);
        apply_reset("reset");

        exec(32'h0022_1821, 3'b000, 0, 0, "addu");
        exec(32'h8C22_0004, 3'b001, 0, 3, "lw_wait3");
        exec(32'h1022_0003, 3'b010, 0, 0, "beq_taken");
        exec(32'h1022_0003, 3'b100, 0, 0, "beq_not_taken");
        exec(32'h0C00_0C00, 3'b001, 0, 0, "jal");
        exec(32'h3422_00FF, 3'b000, 0, 0, "ori");
        exec(32'h3C02_1234, 3'b000, 0, 0, "lui");
        exec(32'hAC22_0008, 3'b000, 1, 2, "sw_wait2");
        exec(32'h0800_0010, 3'b000, 0, 0, "j");
        exec(32'h03E0_0008, 3'b000, 0, 0, "jr");
        exec(32'h0000_0000, 3'b000, 0, 0, "nop");
        exec(32'hFC00_0000, 3'b000, 0, 0, "undecoded");
        exec(32'h0022_1820, 3'b000, 0, 0, "add_undecoded");
        exec(32'h1422_0003, 3'b010, 0, 0, "bne");
        exec(32'h1C20_0003, 3'b001, 0, 0, "bgtz");
        exec(32'h1822_0003, 3'b010, 0, 0, "blez_rt_nonzero");
        exec(32'h0022_1823, 3'b000, MEM_WAIT_MAX - 1, 0, "fetch_wait_last");
        exec(32'h8C22_0004, 3'b000, 0, MEM_WAIT_MAX - 1, "lw_wait_last");

        // Abort an addu during its execute cycle.
        void'(build(32'h0022_1821, 3'b000, 0, 0));
        run(32'h0022_1821, 3'b000, 3, "abort_pre");
        exp_q.delete();
        rdy_q.delete();
        apply_reset("abort_reset");
        exec(32'h0022_1821, 3'b000, 0, 0, "after_abort");

        repeat (40) begin
            ri = rand_instr();
            fw = ($urandom_range(0, 9) == 0) ? MEM_WAIT_MAX - 1 : $urandom_range(0, 2);
            mw = ($urandom_range(0, 9) == 0) ? MEM_WAIT_MAX - 1 : $urandom_range(0, 2);
            exec(ri, 3'($urandom_range(0, 7)), fw, mw, "random");
        end

        exec(32'h0022_1821, 3'b000, MEM_WAIT_MAX, 0, "fetch_timeout");
        apply_reset("reset_after_halt");
        exec(32'hAC22_0008, 3'b000, 0, MEM_WAIT_MAX, "sw_timeout");
        apply_reset("reset_after_sw_halt");
        exec(32'h3422_00FF, 3'b000, 0, 0, "ori_after_halt");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
